// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer controller: preset select, count-down with pause/resume, and a bounded alarm phase.
// Includes its own 1-second prescaler, a seconds down-counter and an alarm-duration counter.
//
// state    | meaning
// IDLE     | waiting for a preset selection
// ARMED    | preset loaded, waiting for start
// COUNTING | seconds counter decrementing on each tick
// PAUSED   | prescaler and seconds counter frozen
// ALARM    | alarm phase, bounded by ALARM_SEC ticks or ended by acknowledge
module kitchen_timer_ctrl #(
  parameter int CNT_W       = 10,
  parameter int N_MODE      = 3,
  parameter int PRESET_STEP = 60,
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_SEC   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_MODE-1:0] mode_sel,
  input  logic              start,
  input  logic              stop,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  remaining,
  output logic              counting,
  output logic              alarm,
  output logic              done_pulse
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);

  if (N_MODE * PRESET_STEP > (2 ** CNT_W) - 1) begin : g_param_check
    $error("kitchen_timer_ctrl: largest preset does not fit in CNT_W bits");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    COUNTING = 3'd2,
    PAUSED   = 3'd3,
    ALARM    = 3'd4
  } state_t;

  state_t            state_q, state_nx;
  logic              start_d, start_fall;
  logic [PW-1:0]     presc;
  logic [AW-1:0]     alarm_cnt;
  logic [CNT_W-1:0]  preset_val;
  logic              mode_any, run, tick;
  logic              counting_nx, alarm_nx, done_nx;
  logic              start_count, enter_alarm;

  assign start_fall  = start_d & ~start;
  assign mode_any    = |mode_sel;
  assign run         = (state_q == COUNTING) || (state_q == ALARM);
  assign tick        = run && (presc == PW'(TICK_DIV - 1));
  assign start_count = (state_q == ARMED) && (state_nx == COUNTING);
  assign enter_alarm = (state_q == COUNTING) && (state_nx == ALARM);
  assign state       = state_q;

  // Lowest set bit wins: scan downward so the last assignment is the lowest index.
  always_comb begin
    preset_val = '0;
    for (int k = N_MODE - 1; k >= 0; k--) begin
      if (mode_sel[k]) preset_val = CNT_W'((k + 1) * PRESET_STEP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      start_d    <= 1'b0;
      counting   <= 1'b0;
      alarm      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_nx;
      start_d    <= start;
      counting   <= counting_nx;
      alarm      <= alarm_nx;
      done_pulse <= done_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (mode_any) state_nx = ARMED;
        ARMED:    if (start_fall) state_nx = COUNTING;
        COUNTING: begin
          // A terminal tick beats a simultaneous pause request.
          if (tick && (remaining == CNT_W'(1))) state_nx = ALARM;
          else if (start_fall)                  state_nx = PAUSED;
        end
        PAUSED:   if (start_fall) state_nx = COUNTING;
        ALARM:    if (start_fall || (tick && (alarm_cnt == AW'(ALARM_SEC - 1)))) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    counting_nx = (state_nx == COUNTING);
    alarm_nx    = (state_nx == ALARM);
    done_nx     = enter_alarm;
  end

  // Prescaler holds its value through PAUSED so resume continues the partial second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        presc <= '0;
    else if (stop)                       presc <= '0;
    else if (start_count || enter_alarm) presc <= '0;
    else if (run)                        presc <= tick ? '0 : presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        alarm_cnt <= '0;
    else if (stop || enter_alarm)        alarm_cnt <= '0;
    else if ((state_q == ALARM) && tick) alarm_cnt <= alarm_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
    end else if (stop) begin
      remaining <= '0;
    end else begin
      case (state_q)
        IDLE, ARMED: if (mode_any) remaining <= preset_val;
        COUNTING:    if (tick) remaining <= remaining - 1'b1;
        default:     ;
      endcase
    end
  end
endmodule
